// File: rtl/chirp_band_collector.sv
// chirp_band_collector: gathers accepted band indices during a chirp sweep
// into a one-hot mask and publishes the mask, its population count and an
// empty flag when the sweep ends.
// Optional feature macro: CHIRP_COLLECTOR_DUP_COUNT_EN enables the saturating
// duplicate-index counter; without it dup_count is tied to zero.
module chirp_band_collector #(
  parameter int unsigned MAX_BANDS  = 64,
  parameter int unsigned BAND_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  band_valid,
  input  logic [BAND_WIDTH-1:0] band_in,
  output logic                  band_ready,
  input  logic                  sweep_done,
  output logic [MAX_BANDS-1:0]  used_bands,
  output logic                  used_valid,
  output logic [BAND_WIDTH:0]   band_count,
  output logic                  empty,
  output logic                  range_err,
  output logic [7:0]            dup_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  clear, accept, publish;
  logic [MAX_BANDS-1:0]  sel;
  logic                  in_range, hit_prev;
  logic [MAX_BANDS-1:0]  acc_q, acc_d;
  logic [BAND_WIDTH:0]   cnt_q, cnt_d;
  logic                  rerr_q, rerr_d;
  logic [MAX_BANDS-1:0]  used_bands_q, used_bands_d;
  logic [BAND_WIDTH:0]   band_count_q, band_count_d;
  logic                  empty_q, empty_d;
  logic                  used_valid_q, used_valid_d;

  // State register plus the deferred-start flag raised during PUBLISH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic; start outranks sweep_done in COLLECT
  always_comb begin
    state_d = state_q;
    pend_d  = 1'b0;
    unique case (state_q)
      IDLE:    if (start || pend_q) state_d = COLLECT;
      COLLECT: begin
        if (start)           state_d = COLLECT;
        else if (sweep_done) state_d = PUBLISH;
      end
      PUBLISH: begin
        state_d = IDLE;
        pend_d  = start;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    band_ready = (state_q == COLLECT);
    publish    = (state_q == PUBLISH);
    clear      = ((state_q == IDLE) && (start || pend_q)) ||
                 ((state_q == COLLECT) && start);
    // a restart discards whatever is offered in the same cycle
    accept     = band_ready && band_valid && !start;
  end

  // One-hot decode of band_in; out-of-range indices decode to all zeros
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < MAX_BANDS; i++) begin
      sel[i] = (band_in == BAND_WIDTH'(i));
    end
    in_range = |sel;
    hit_prev = |(sel & acc_q);
  end

  // Accumulator, distinct counter, range flag and publication registers
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rerr_d       = rerr_q;
    used_bands_d = used_bands_q;
    band_count_d = band_count_q;
    empty_d      = empty_q;
    used_valid_d = publish;
    if (clear) begin
      acc_d  = '0;
      cnt_d  = '0;
      rerr_d = 1'b0;
    end else if (accept) begin
      if (!in_range) begin
        rerr_d = 1'b1;
      end else if (!hit_prev) begin
        acc_d = acc_q | sel;
        cnt_d = cnt_q + {{BAND_WIDTH{1'b0}}, 1'b1};
      end
    end
    if (publish) begin
      band_count_d = cnt_q;
      empty_d      = (cnt_q == '0);
      used_bands_d = (cnt_q == '0) ? {{(MAX_BANDS-1){1'b0}}, 1'b1} : acc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      rerr_q       <= 1'b0;
      used_bands_q <= {{(MAX_BANDS-1){1'b0}}, 1'b1};
      band_count_q <= '0;
      empty_q      <= 1'b1;
      used_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rerr_q       <= rerr_d;
      used_bands_q <= used_bands_d;
      band_count_q <= band_count_d;
      empty_q      <= empty_d;
      used_valid_q <= used_valid_d;
    end
  end

  assign used_bands = used_bands_q;
  assign band_count = band_count_q;
  assign empty      = empty_q;
  assign used_valid = used_valid_q;
  assign range_err  = rerr_q;

`ifdef CHIRP_COLLECTOR_DUP_COUNT_EN
  logic [7:0] dup_q, dup_d;

  // Saturating count of accepted in-range indices already in the mask
  always_comb begin
    dup_d = dup_q;
    if (clear) begin
      dup_d = '0;
    end else if (accept && hit_prev && (dup_q != '1)) begin
      dup_d = dup_q + 8'd1;
    end
  end

  // Duplicate counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dup_q <= '0;
    else          dup_q <= dup_d;
  end

  assign dup_count = dup_q;
`else
  assign dup_count = '0;
`endif

endmodule

// File: tb/tb_chirp_band_collector.sv
// Bench for chirp_band_collector: two instances (64 bands and 40 bands) share
// one stimulus stream; a set-based reference model predicts each publication.
module tb_chirp_band_collector;

  logic        clk = 1'b0;
  logic        reset_n, start, band_valid, sweep_done;
  logic [5:0]  band_in;

  logic        a_ready, a_valid, a_empty, a_rerr;
  logic [63:0] a_bands;
  logic [6:0]  a_count;
  logic [7:0]  a_dup;
  logic        b_ready, b_valid, b_empty, b_rerr;
  logic [39:0] b_bands;
  logic [6:0]  b_count;
  logic [7:0]  b_dup;

  always #5 clk = ~clk;

  chirp_band_collector #(.MAX_BANDS(64), .BAND_WIDTH(6)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start), .band_valid(band_valid),
    .band_in(band_in), .band_ready(a_ready), .sweep_done(sweep_done),
    .used_bands(a_bands), .used_valid(a_valid), .band_count(a_count),
    .empty(a_empty), .range_err(a_rerr), .dup_count(a_dup));

  chirp_band_collector #(.MAX_BANDS(40), .BAND_WIDTH(6)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .band_valid(band_valid),
    .band_in(band_in), .band_ready(b_ready), .sweep_done(sweep_done),
    .used_bands(b_bands), .used_valid(b_valid), .band_count(b_count),
    .empty(b_empty), .range_err(b_rerr), .dup_count(b_dup));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: per instance, the set of bands seen since the last start
  int unsigned maxb [2] = '{64, 40};
  logic [63:0] m_set  [2];
  int          m_dup  [2];
  bit          m_rerr [2];
  logic [63:0] p_mask [2];
  int          p_cnt  [2];
  bit          p_empty[2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_set[k] = '0; m_dup[k] = 0; m_rerr[k] = 1'b0;
      p_mask[k] = 64'd1; p_cnt[k] = 0; p_empty[k] = 1'b1;
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      m_set[k] = '0; m_dup[k] = 0; m_rerr[k] = 1'b0;
    end
  endtask

  task automatic m_accept(input int b);
    for (int k = 0; k < 2; k++) begin
      if (b < int'(maxb[k])) begin
        if (m_set[k][b]) begin
          if (m_dup[k] < 255) m_dup[k]++;
        end else begin
          m_set[k][b] = 1'b1;
        end
      end else begin
        m_rerr[k] = 1'b1;
      end
    end
  endtask

  task automatic m_publish();
    for (int k = 0; k < 2; k++) begin
      p_cnt[k]   = $countones(m_set[k]);
      p_empty[k] = (p_cnt[k] == 0);
      p_mask[k]  = p_empty[k] ? 64'd1 : m_set[k];
    end
  endtask

  function automatic int exp_dup(input int k);
`ifdef CHIRP_COLLECTOR_DUP_COUNT_EN
    return m_dup[k];
`else
    return 0 * k;
`endif
  endfunction

  task automatic check_all(input string tag, input bit exp_valid, input bit exp_ready);
    check({tag, ".a.ready"}, 64'(a_ready), 64'(exp_ready));
    check({tag, ".a.valid"}, 64'(a_valid), 64'(exp_valid));
    check({tag, ".a.bands"}, a_bands, p_mask[0]);
    check({tag, ".a.count"}, 64'(a_count), 64'(p_cnt[0]));
    check({tag, ".a.empty"}, 64'(a_empty), 64'(p_empty[0]));
    check({tag, ".a.rerr"},  64'(a_rerr), 64'(m_rerr[0]));
    check({tag, ".a.dup"},   64'(a_dup), 64'(exp_dup(0)));
    check({tag, ".b.ready"}, 64'(b_ready), 64'(exp_ready));
    check({tag, ".b.valid"}, 64'(b_valid), 64'(exp_valid));
    check({tag, ".b.bands"}, 64'(b_bands), p_mask[1]);
    check({tag, ".b.count"}, 64'(b_count), 64'(p_cnt[1]));
    check({tag, ".b.empty"}, 64'(b_empty), 64'(p_empty[1]));
    check({tag, ".b.rerr"},  64'(b_rerr), 64'(m_rerr[1]));
    check({tag, ".b.dup"},   64'(b_dup), 64'(exp_dup(1)));
  endtask

  // Apply one cycle of inputs; return 1 time unit after the consuming edge
  task automatic step(input bit st, input bit v, input int b, input bit sd);
    start = st; band_valid = v; band_in = b[5:0]; sweep_done = sd;
    @(posedge clk); #1;
    start = 1'b0; band_valid = 1'b0; sweep_done = 1'b0; band_in = '0;
  endtask

  task automatic begin_sweep(input string tag);
    step(1, 0, 0, 0);
    m_clear();
    check_all({tag, ".collect"}, 1'b0, 1'b1);
  endtask

  task automatic band(input int b);
    step(0, 1, b, 0);
    m_accept(b);
  endtask

  // Called right after the sweep_done edge: valid must appear one cycle later
  task automatic expect_publish(input string tag);
    check_all({tag, ".pub0"}, 1'b0, 1'b0);
    m_publish();
    step(0, 0, 0, 0);
    check_all({tag, ".pub1"}, 1'b1, 1'b0);
    step(0, 0, 0, 0);
    check_all({tag, ".pub2"}, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; band_valid = 1'b0; sweep_done = 1'b0; band_in = '0;
    m_reset();
    #12;
    check_all("reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    step(0, 0, 0, 0);
    check_all("idle", 1'b0, 1'b0);

    // Bands 3, 7, 63 (63 is out of range for the 40-band instance)
    begin_sweep("s37_63");
    band(3); band(7); band(63);
    step(0, 0, 0, 1);
    expect_publish("s37_63");

    // Empty sweep
    begin_sweep("empty");
    step(0, 0, 0, 1);
    expect_publish("empty");

    // Duplicates
    begin_sweep("dup5");
    band(5); band(5); band(5);
    step(0, 0, 0, 1);
    expect_publish("dup5");

    // Out of range for 40 bands, then band 2
    begin_sweep("range");
    band(45); band(2);
    step(0, 0, 0, 1);
    expect_publish("range");

    // Band accepted together with sweep_done
    begin_sweep("same9");
    band(1);
    step(0, 1, 9, 1);
    m_accept(9);
    expect_publish("same9");

    // sweep_done while idle is ignored
    step(0, 0, 0, 1);
    check_all("idle_sd0", 1'b0, 1'b0);
    step(0, 0, 0, 0);
    check_all("idle_sd1", 1'b0, 1'b0);

    // start together with sweep_done restarts without publishing
    begin_sweep("st_sd");
    band(20); band(50);
    step(1, 0, 0, 1);
    m_clear();
    check_all("st_sd.r0", 1'b0, 1'b1);
    step(0, 0, 0, 0);
    check_all("st_sd.r1", 1'b0, 1'b1);
    band(11);
    step(0, 0, 0, 1);
    expect_publish("st_sd");

    // start mid-collection discards the accumulator
    begin_sweep("restart");
    band(10); band(12); band(41);
    step(1, 0, 0, 0);
    m_clear();
    check_all("restart.r", 1'b0, 1'b1);
    band(13);
    step(0, 0, 0, 1);
    expect_publish("restart");

    // start during PUBLISH begins a new collection after the IDLE cycle
    begin_sweep("pubst");
    band(30); band(33);
    step(0, 0, 0, 1);
    check_all("pubst.pub0", 1'b0, 1'b0);
    m_publish();
    step(1, 0, 0, 0);
    check_all("pubst.pub1", 1'b1, 1'b0);
    step(0, 0, 0, 0);
    m_clear();
    check_all("pubst.col", 1'b0, 1'b1);
    band(4); band(4);
    step(0, 0, 0, 1);
    expect_publish("pubst2");

    // Duplicate counter saturation
    begin_sweep("sat");
    for (int i = 0; i < 300; i++) band(1);
    step(0, 0, 0, 1);
    expect_publish("sat");

    // Randomized sweeps
    for (int s = 0; s < 25; s++) begin
      int n;
      bit v;
      int b;
      begin_sweep($sformatf("rnd%0d", s));
      n = $urandom_range(0, 25);
      for (int i = 0; i < n; i++) begin
        v = ($urandom % 4) != 0;
        b = (($urandom % 3) == 0) ? int'($urandom % 8) : int'($urandom % 64);
        step(0, v, b, 0);
        if (v) m_accept(b);
      end
      v = $urandom % 2;
      b = $urandom % 64;
      step(0, v, b, 1);
      if (v) m_accept(b);
      expect_publish($sformatf("rnd%0d", s));
    end

    // Reset during a collection: no publication, reset values
    begin_sweep("rstmid");
    band(8); band(45);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    check_all("rstmid.r0", 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0);
    check_all("rstmid.r1", 1'b0, 1'b0);
    step(0, 0, 0, 1);
    check_all("rstmid.r2", 1'b0, 1'b0);
    step(0, 0, 0, 0);
    check_all("rstmid.r3", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chirp_band_collector.md
CHIRP_BAND_COLLECTOR -- requirements
Module: chirp_band_collector

Interface
REQ-001 Parameter MAX_BANDS, default 64, SHALL set the number of bands and the width of the one-hot mask.
REQ-002 Parameter BAND_WIDTH, default 6, SHALL set the band index width; MAX_BANDS <= 2^BAND_WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 start  input  1  SHALL be a one-cycle pulse that clears the accumulator and begins a collection.
REQ-006 band_valid  input  1  SHALL qualify band_in.
REQ-007 band_in  input  BAND_WIDTH  SHALL carry the band index to record.
REQ-008 band_ready  output  1  SHALL indicate that band_in is accepted this cycle if band_valid is high.
REQ-009 sweep_done  input  1  SHALL be a one-cycle pulse that ends the collection and requests publication.
REQ-010 used_bands  output  MAX_BANDS  SHALL carry the published one-hot band mask.
REQ-011 used_valid  output  1  SHALL pulse for one cycle when used_bands is updated.
REQ-012 band_count  output  BAND_WIDTH+1  SHALL carry the number of distinct bands in the published mask.
REQ-013 empty  output  1  SHALL be high when the last publication contained no recorded band.
REQ-014 range_err  output  1  SHALL be a sticky flag for band_in >= MAX_BANDS since the last start.
REQ-015 dup_count  output  8  SHALL carry the number of duplicate band indices since the last start.

Function
REQ-016 States SHALL be IDLE, COLLECT, and PUBLISH.
REQ-017 IDLE: band_ready=0; start -> COLLECT, with accumulator=0, distinct counter=0, dup_count=0, and range_err=0.
REQ-018 COLLECT: band_ready=1; an accept (band_valid & band_ready) with band_in < MAX_BANDS SHALL set accumulator bit band_in.
REQ-019 When the accepted bit was previously clear, the distinct counter SHALL increment; when it was already set, dup_count SHALL increment, saturating at 255.
REQ-020 An accepted band_in >= MAX_BANDS SHALL leave the accumulator unchanged and SHALL set range_err.
REQ-021 sweep_done in COLLECT -> PUBLISH; an accept in the same cycle SHALL be included in the publication.
REQ-022 PUBLISH (exactly one cycle): band_ready=0; used_bands, band_count, and empty SHALL load; used_valid=1 during the cycle after the load edge; next state IDLE.
REQ-023 Empty sweep (distinct count 0): used_bands SHALL be 1 (band 0 default), band_count=0, empty=1.
REQ-024 start in COLLECT SHALL restart the collection and discard the accumulator; start in PUBLISH SHALL be honoured after the publish completes, i.e. IDLE->COLLECT on the next cycle.
REQ-025 start and sweep_done in the same cycle SHALL take start priority; no publication occurs.
REQ-026 sweep_done in IDLE or PUBLISH SHALL be ignored.
REQ-027 used_bands, band_count, and empty SHALL hold their values between publications.
REQ-028 The latency from sweep_done to used_valid high SHALL be 2 cycles.

Reset
REQ-029 Asserting reset_n low SHALL force state IDLE, band_ready=0, used_bands=1, used_valid=0, band_count=0, empty=1, range_err=0, dup_count=0, accumulator=0.
REQ-030 Reset mid-COLLECT SHALL discard the collection with no publication.

Configuration
REQ-031 Macro CHIRP_COLLECTOR_DUP_COUNT_EN defined: dup_count SHALL behave per REQ-019.
REQ-032 Macro CHIRP_COLLECTOR_DUP_COUNT_EN undefined: dup_count SHALL be constant 0 and no counter logic SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-033 Stimulus: start, then bands 3, 7, 63, then sweep_done. Required: used_bands = bits {3, 7, 63}, band_count=3, empty=0, used_valid high exactly 1 cycle, 2 cycles after sweep_done.
REQ-034 Stimulus: start, then sweep_done with no bands. Required: used_bands=1, band_count=0, empty=1.
REQ-035 Stimulus: start, then bands 5, 5, 5, then sweep_done. Required: band_count=1 and dup_count=2 with the macro defined; dup_count=0 with the macro undefined.
REQ-036 Stimulus: MAX_BANDS=40, start, band 45, band 2, sweep_done. Required: range_err=1, used_bands = bit 2 only.
REQ-037 Stimulus: band 9 accepted in the same cycle as sweep_done. Required: bit 9 present in the publication.
REQ-038 Stimulus: start+sweep_done in the same cycle, or reset_n low mid-COLLECT. Required: no used_valid pulse, outputs keep prior/reset values.
